// File: rtl/obj_commit_scheduler_if.sv
// Request/table bundle for obj_commit_scheduler (scheduler uses the slave modport).
// The drop_cnt signal exists only when OBJ_SCHED_STATS_EN is defined.
interface obj_commit_scheduler_if #(
    parameter int OBJ_WIDTH = 56
);
    logic                 vblank;
    logic                 req0_valid;
    logic                 req0_ready;
    logic [1:0]           req0_op;
    logic [3:0]           req0_idx;
    logic [OBJ_WIDTH-1:0] req0_obj;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [1:0]           req1_op;
    logic [3:0]           req1_idx;
    logic [OBJ_WIDTH-1:0] req1_obj;
    logic                 tbl_we;
    logic [3:0]           tbl_addr;
    logic [OBJ_WIDTH-1:0] tbl_wdata;
    logic [5:0]           obj_len;
    logic                 err;
    logic                 frame_done;
`ifdef OBJ_SCHED_STATS_EN
    logic [7:0]           drop_cnt;
`endif

    modport master (
        output vblank,
               req0_valid, req0_op, req0_idx, req0_obj,
               req1_valid, req1_op, req1_idx, req1_obj,
        input  req0_ready, req1_ready,
               tbl_we, tbl_addr, tbl_wdata, obj_len, err, frame_done
`ifdef OBJ_SCHED_STATS_EN
               , drop_cnt
`endif
    );

    modport slave (
        input  vblank,
               req0_valid, req0_op, req0_idx, req0_obj,
               req1_valid, req1_op, req1_idx, req1_obj,
        output req0_ready, req1_ready,
               tbl_we, tbl_addr, tbl_wdata, obj_len, err, frame_done
`ifdef OBJ_SCHED_STATS_EN
               , drop_cnt
`endif
    );
endinterface

// File: rtl/obj_commit_scheduler.sv
// Two-requester object-table update scheduler: round-robin arbiter, request FIFO, vblank-gated commit.
// Optional drop counter output enabled by defining OBJ_SCHED_STATS_EN.
module obj_commit_scheduler #(
    parameter int OBJ_WIDTH  = 56,
    parameter int MAX_LEN    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk25,
    input  logic                  rst,
    obj_commit_scheduler_if.slave bus
);
    localparam int IDX_W   = $clog2(MAX_LEN);
    localparam int LEN_W   = 6;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 2 + IDX_W + OBJ_WIDTH;
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SET   = 2'd1,
        OP_CLEAR = 2'd2,
        OP_NOP   = 2'd3
    } op_e;

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic                 vblank_q;
    logic                 rr_q;
    logic                 grant0, grant1, push, pop, window_close;
    logic                 fifo_full, fifo_empty;
    logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
    logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   push_entry, head_entry;
    op_e                  head_op;
    logic [IDX_W-1:0]     head_idx;
    logic [OBJ_WIDTH-1:0] head_obj;

    logic                 we_d, err_d, clear_d;
    logic [LEN_W-1:0]     len_d;
    logic [IDX_W-1:0]     wr_addr_d;

    logic                 tbl_we_q, err_q, frame_done_q;
    logic [IDX_W-1:0]     tbl_addr_q;
    logic [OBJ_WIDTH-1:0] tbl_wdata_q;
    logic [LEN_W-1:0]     obj_len_q;

    // Round-robin pointer only matters when both requesters compete.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || !rr_q);
        grant1 = bus.req1_valid && (!bus.req0_valid ||  rr_q);
    end

    assign bus.req0_ready = grant0 && !fifo_full;
    assign bus.req1_ready = grant1 && !fifo_full;
    assign push       = (grant0 || grant1) && !fifo_full;
    assign push_entry = grant0 ? {bus.req0_op, bus.req0_idx, bus.req0_obj}
                               : {bus.req1_op, bus.req1_idx, bus.req1_obj};

    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            rr_q <= 1'b0;
        end else if (push && bus.req0_valid && bus.req1_valid) begin
            rr_q <= ~rr_q;
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk25) begin
        if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_entry;
    end

    assign head_entry = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign head_op    = op_e'(head_entry[ENTRY_W-1 -: 2]);
    assign head_idx   = head_entry[OBJ_WIDTH +: IDX_W];
    assign head_obj   = head_entry[OBJ_WIDTH-1:0];

    // vblank_q resets high so a vblank already active at reset release is not an edge.
    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            vblank_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            vblank_q <= bus.vblank;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.vblank && !vblank_q)    state_d = COMMIT;
            COMMIT:  if (!bus.vblank || fifo_empty)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop          = 1'b0;
        window_close = 1'b0;
        if (state_q == COMMIT) begin
            pop          = bus.vblank && !fifo_empty;
            window_close = !bus.vblank || fifo_empty;
        end
    end

    // Decode the popped entry against the current committed length.
    always_comb begin
        we_d      = 1'b0;
        err_d     = 1'b0;
        clear_d   = 1'b0;
        len_d     = obj_len_q;
        wr_addr_d = (head_op == OP_ADD) ? obj_len_q[IDX_W-1:0] : head_idx;
        if (pop) begin
            case (head_op)
                OP_ADD: begin
                    if (obj_len_q < MAX_LEN_V) begin
                        we_d  = 1'b1;
                        len_d = obj_len_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_SET: begin
                    if (LEN_W'(head_idx) < obj_len_q) we_d  = 1'b1;
                    else                               err_d = 1'b1;
                end
                OP_CLEAR: begin
                    clear_d = 1'b1;
                    len_d   = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            tbl_we_q     <= 1'b0;
            tbl_addr_q   <= '0;
            tbl_wdata_q  <= '0;
            obj_len_q    <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tbl_we_q     <= we_d;
            err_q        <= err_d;
            frame_done_q <= window_close;
            obj_len_q    <= len_d;
            if (we_d) begin
                tbl_addr_q  <= wr_addr_d;
                tbl_wdata_q <= head_obj;
            end
        end
    end

    assign bus.tbl_we     = tbl_we_q;
    assign bus.tbl_addr   = tbl_addr_q;
    assign bus.tbl_wdata  = tbl_wdata_q;
    assign bus.obj_len    = obj_len_q;
    assign bus.err        = err_q;
    assign bus.frame_done = frame_done_q;

`ifdef OBJ_SCHED_STATS_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else if (clear_d) begin
            drop_cnt_q <= '0;
        end else if (err_d && drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_obj_commit_scheduler.sv
// Self-checking bench for obj_commit_scheduler: directed scenarios then random traffic
// against a queue-based reference model; drop_cnt checked when OBJ_SCHED_STATS_EN is defined.
module tb_obj_commit_scheduler;
    localparam int OW = 56;
    localparam logic [1:0] ADD = 2'd0, SET = 2'd1, CLR = 2'd2, NOP = 2'd3;

    logic clk25 = 1'b0;
    logic rst;
    always #20 clk25 = ~clk25;

    obj_commit_scheduler_if #(.OBJ_WIDTH(OW)) bus ();

    obj_commit_scheduler #(.OBJ_WIDTH(OW), .MAX_LEN(16), .FIFO_DEPTH(4)) dut (
        .clk25 (clk25),
        .rst   (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]    op;
        logic [3:0]    idx;
        logic [OW-1:0] obj;
    } req_t;

    int checks = 0;
    int failures = 0;

    req_t          mq[$];
    int            m_len, m_drop;
    bit            m_rr, m_win, m_vbq;
    bit            exp_we, exp_err, exp_fd;
    logic [3:0]    exp_addr;
    logic [OW-1:0] exp_data;

    int            n_writes, n_errs, n_fd;
    int            dut_grants[$];
    logic [3:0]    last_addr;
    logic [OW-1:0] last_data;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        m_len = 0; m_drop = 0;
        m_rr = 1'b0; m_win = 1'b0; m_vbq = 1'b1;
        exp_we = 1'b0; exp_err = 1'b0; exp_fd = 1'b0;
    endtask

    function automatic logic [OW-1:0] rndObj();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[OW-1:0];
    endfunction

    // One clock: check ready, advance the model across the edge, check registered outputs.
    task automatic runCycle();
        bit full, any, winner, pop, leave, enter, exp_r0, exp_r1;
        req_t h, r;
        #1;
        full   = (mq.size() == 4);
        any    = bus.req0_valid || bus.req1_valid;
        winner = (bus.req0_valid && bus.req1_valid) ? m_rr : bus.req1_valid;
        exp_r0 = any && !winner && !full;
        exp_r1 = any &&  winner && !full;
        checkOutput("req0_ready", bus.req0_ready, exp_r0);
        checkOutput("req1_ready", bus.req1_ready, exp_r1);
        if (bus.req0_valid && bus.req0_ready) dut_grants.push_back(0);
        if (bus.req1_valid && bus.req1_ready) dut_grants.push_back(1);

        pop   = m_win && bus.vblank && mq.size() != 0;
        leave = m_win && (!bus.vblank || mq.size() == 0);
        enter = !m_win && bus.vblank && !m_vbq;
        exp_we = 1'b0; exp_err = 1'b0; exp_fd = leave;
        if (pop) begin
            h = mq.pop_front();
            case (h.op)
                ADD: if (m_len < 16) begin
                         exp_we = 1'b1; exp_addr = 4'(m_len); exp_data = h.obj; m_len++;
                     end else exp_err = 1'b1;
                SET: if (int'(h.idx) < m_len) begin
                         exp_we = 1'b1; exp_addr = h.idx; exp_data = h.obj;
                     end else exp_err = 1'b1;
                CLR: begin m_len = 0; m_drop = 0; end
                default: ;
            endcase
            if (exp_err && m_drop < 255) m_drop++;
        end
        if (any && !full) begin
            r.op  = winner ? bus.req1_op  : bus.req0_op;
            r.idx = winner ? bus.req1_idx : bus.req0_idx;
            r.obj = winner ? bus.req1_obj : bus.req0_obj;
            mq.push_back(r);
            if (bus.req0_valid && bus.req1_valid) m_rr = !m_rr;
        end
        if (enter)      m_win = 1'b1;
        else if (leave) m_win = 1'b0;
        m_vbq = bus.vblank;

        @(posedge clk25);
        #1;
        checkOutput("tbl_we", bus.tbl_we, exp_we);
        checkOutput("err", bus.err, exp_err);
        checkOutput("frame_done", bus.frame_done, exp_fd);
        checkOutput("obj_len", bus.obj_len, 6'(m_len));
        if (exp_we) begin
            checkOutput("tbl_addr", bus.tbl_addr, exp_addr);
            checkOutput("tbl_wdata", bus.tbl_wdata, exp_data);
        end
`ifdef OBJ_SCHED_STATS_EN
        checkOutput("drop_cnt", bus.drop_cnt, 8'(m_drop));
`endif
        if (bus.tbl_we) begin
            n_writes++; last_addr = bus.tbl_addr; last_data = bus.tbl_wdata;
        end
        if (bus.err)        n_errs++;
        if (bus.frame_done) n_fd++;
    endtask

    task automatic applyStimulus(input bit vb,
                                 input bit v0, input logic [1:0] o0, input logic [3:0] i0, input logic [OW-1:0] d0,
                                 input bit v1, input logic [1:0] o1, input logic [3:0] i1, input logic [OW-1:0] d1);
        bus.vblank     = vb;
        bus.req0_valid = v0; bus.req0_op = o0; bus.req0_idx = i0; bus.req0_obj = d0;
        bus.req1_valid = v1; bus.req1_op = o1; bus.req1_idx = i1; bus.req1_obj = d1;
        runCycle();
    endtask

    task automatic idle(input bit vb, input int n);
        for (int i = 0; i < n; i++) applyStimulus(vb, 0, NOP, 0, '0, 0, NOP, 0, '0);
    endtask

    task automatic push0(input logic [1:0] op, input logic [3:0] idx, input logic [OW-1:0] obj);
        applyStimulus(0, 1, op, idx, obj, 0, NOP, 0, '0);
    endtask

    task automatic frame(input int high);
        idle(1, high);
        idle(0, 2);
    endtask

    initial begin
        int w0, e0, f0;
        logic [OW-1:0] d;
        bit vb, v0, v1;
        int r;
        logic [1:0] o0, o1;

        rst = 1'b0;
        bus.vblank = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_op = NOP; bus.req0_idx = '0; bus.req0_obj = '0;
        bus.req1_valid = 1'b0; bus.req1_op = NOP; bus.req1_idx = '0; bus.req1_obj = '0;
        modelReset();
        n_writes = 0; n_errs = 0; n_fd = 0;

        repeat (2) @(posedge clk25);
        #1;
        checkOutput("rst_tbl_we", bus.tbl_we, 0);
        checkOutput("rst_obj_len", bus.obj_len, 0);
        checkOutput("rst_err", bus.err, 0);
        checkOutput("rst_frame_done", bus.frame_done, 0);
        checkOutput("rst_tbl_addr", bus.tbl_addr, 0);
        checkOutput("rst_tbl_wdata", bus.tbl_wdata, 0);
        #9 rst = 1'b1;
        idle(0, 2);

        $display("[TB] three ADDs outside vblank, then one window");
        push0(ADD, 0, 56'h11_1111_1111_1111);
        push0(ADD, 0, 56'h22_2222_2222_2222);
        push0(ADD, 0, 56'h33_3333_3333_3333);
        idle(0, 3);
        checkOutput("s1_no_write_before_vblank", n_writes, 0);
        idle(1, 6);
        idle(0, 2);
        checkOutput("s1_writes", n_writes, 3);
        checkOutput("s1_obj_len", bus.obj_len, 3);
        checkOutput("s1_frame_done_count", n_fd, 1);

        $display("[TB] both requesters every cycle");
        dut_grants.delete();
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, ADD, 0, rndObj(), 1, ADD, 0, rndObj());
        checkOutput("s2_grant_count", dut_grants.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("s2_grant%0d", i), (i < dut_grants.size()) ? dut_grants[i] : -1, i % 2);
        idle(0, 1);
        frame(6);
        checkOutput("s2_obj_len", bus.obj_len, 7);

        $display("[TB] fill table to capacity");
        push0(CLR, 0, '0);
        frame(3);
        checkOutput("s3_cleared", bus.obj_len, 0);
        e0 = n_errs;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 4; k++) push0(ADD, 0, rndObj());
            frame(7);
        end
        checkOutput("s3_full_len", bus.obj_len, 16);
        w0 = n_writes;
        push0(ADD, 0, rndObj());
        frame(3);
        checkOutput("s3_overflow_err", n_errs - e0, 1);
        checkOutput("s3_overflow_nowrite", n_writes - w0, 0);
        checkOutput("s3_len_capped", bus.obj_len, 16);
`ifdef OBJ_SCHED_STATS_EN
        checkOutput("s3_drop_cnt", bus.drop_cnt, 1);
`endif

        $display("[TB] SET bounds");
        push0(CLR, 0, '0);
        push0(ADD, 0, rndObj());
        push0(ADD, 0, rndObj());
        frame(5);
        checkOutput("s4_len2", bus.obj_len, 2);
        e0 = n_errs; w0 = n_writes;
        push0(SET, 5, rndObj());
        frame(3);
        checkOutput("s4_set_oob_err", n_errs - e0, 1);
        checkOutput("s4_set_oob_nowrite", n_writes - w0, 0);
        d = 56'hAB_CDEF_0123_4567;
        push0(SET, 1, d);
        frame(3);
        checkOutput("s4_set_addr", last_addr, 1);
        checkOutput("s4_set_data", last_data, d);

        $display("[TB] window closes with entries pending");
        for (int k = 0; k < 4; k++) push0(ADD, 0, rndObj());
        w0 = n_writes; f0 = n_fd;
        idle(1, 3);
        idle(0, 2);
        checkOutput("s5_partial_writes", n_writes - w0, 2);
        checkOutput("s5_partial_fd", n_fd - f0, 1);
        frame(6);
        checkOutput("s5_remaining_writes", n_writes - w0, 4);
        checkOutput("s5_obj_len", bus.obj_len, 6);

        $display("[TB] reset during commit");
        for (int k = 0; k < 4; k++) push0(ADD, 0, rndObj());
        idle(1, 2);
        checkOutput("s6_write_in_flight", bus.tbl_we, 1);
        #5 rst = 1'b0;
        #1;
        checkOutput("s6_rst_tbl_we", bus.tbl_we, 0);
        checkOutput("s6_rst_obj_len", bus.obj_len, 0);
        checkOutput("s6_rst_err", bus.err, 0);
        modelReset();
        repeat (2) @(posedge clk25);
        #9 rst = 1'b1;
        w0 = n_writes;
        idle(1, 4);
        idle(0, 2);
        idle(1, 5);
        idle(0, 2);
        checkOutput("s6_no_writes_after_reset", n_writes - w0, 0);

        $display("[TB] random traffic");
        vb = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) == 0) vb = !vb;
            v0 = ($urandom_range(0, 2) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 19);
            o0 = (r < 11) ? ADD : (r < 17) ? SET : (r < 18) ? CLR : NOP;
            r = $urandom_range(0, 19);
            o1 = (r < 11) ? ADD : (r < 17) ? SET : (r < 18) ? CLR : NOP;
            applyStimulus(vb, v0, o0, 4'($urandom_range(0, 15)), rndObj(),
                              v1, o1, 4'($urandom_range(0, 15)), rndObj());
        end
        idle(0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
